// File: rtl/local_align_pkg.sv
// Shared types and default widths for the local-alignment datapath.
package local_align_pkg;

  localparam int SCORE_BITS_WIDTH = 8;
  localparam int ROW_BITS_WIDTH   = 5;
  localparam int COL_BITS_WIDTH   = 5;

  typedef logic [SCORE_BITS_WIDTH-1:0] score_t;
  typedef logic [ROW_BITS_WIDTH-1:0]   row_t;
  typedef logic [COL_BITS_WIDTH-1:0]   col_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } tracker_state_e;

endpackage

// File: rtl/max_score_tracker.sv
// Running maximum over the per-cycle winners of max_of_n for one alignment
// matrix; the peak score and its coordinates are offered on a valid/ready
// result port once the last beat has been folded in.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; last result (if any) still visible on res_*
// TRACK | folding beats into the running best; busy = 1
// DONE  | result offered (res_valid = 1) until the consumer takes it
module max_score_tracker
  import local_align_pkg::*;
#(
  parameter int SCORE_BITS_WIDTH = local_align_pkg::SCORE_BITS_WIDTH,
  parameter int ROW_BITS_WIDTH   = local_align_pkg::ROW_BITS_WIDTH,
  parameter int COL_BITS_WIDTH   = local_align_pkg::COL_BITS_WIDTH,
  parameter int BEAT_CNT_WIDTH   = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [SCORE_BITS_WIDTH-1:0] in_score,
  input  logic [ROW_BITS_WIDTH-1:0]   in_row,
  input  logic [COL_BITS_WIDTH-1:0]   in_col,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [SCORE_BITS_WIDTH-1:0] res_score,
  output logic [ROW_BITS_WIDTH-1:0]   res_row,
  output logic [COL_BITS_WIDTH-1:0]   res_col,
  output logic [BEAT_CNT_WIDTH-1:0]   res_beats,
  output logic                        err_drop
);

  tracker_state_e state, state_nxt;
  logic           clear_run;
  logic           accept;
  logic           drop;
  logic           have_best;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, plus the clear strobe that opens a new matrix.
  always_comb begin
    state_nxt = state;
    clear_run = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_TRACK;
          clear_run = 1'b1;
        end
      end
      ST_TRACK: begin
        if (in_valid && in_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          if (start) begin
            state_nxt = ST_TRACK;
            clear_run = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept    = (state == ST_TRACK) && in_valid;
  assign drop      = (state != ST_TRACK) && in_valid;
  assign busy      = (state == ST_TRACK);
  assign res_valid = (state == ST_DONE);

  // Compare-and-load of the running best plus the saturating beat counter.
  // The first beat of a matrix loads unconditionally so an all-zero matrix
  // still reports real coordinates; ties keep the earlier beat (strict >).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_best <= 1'b0;
      res_score <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_beats <= '0;
    end else if (clear_run) begin
      have_best <= 1'b0;
      res_score <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_beats <= '0;
    end else if (accept) begin
      if (res_beats != {BEAT_CNT_WIDTH{1'b1}}) res_beats <= res_beats + 1'b1;
      if (!have_best || (in_score > res_score)) begin
        res_score <= in_score;
        res_row   <= in_row;
        res_col   <= in_col;
      end
      have_best <= 1'b1;
    end
  end

  // Sticky drop flag; a drop in the same cycle as start wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_drop <= 1'b0;
    else        err_drop <= (err_drop && !clear_run) || drop;
  end

endmodule

// File: tb/tb_max_score_tracker.sv
// Self-checking bench for max_score_tracker: directed scenarios plus random
// matrices checked against a list-scanning reference of the running peak.
module tb_max_score_tracker;

  localparam int SW = 8;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [SW-1:0] in_score = '0;
  logic [RW-1:0] in_row = '0;
  logic [CW-1:0] in_col = '0;
  logic          res_ready = 1'b0;
  logic          busy;
  logic          res_valid;
  logic [SW-1:0] res_score;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic [BW-1:0] res_beats;
  logic          err_drop;

  max_score_tracker #(
    .SCORE_BITS_WIDTH(SW), .ROW_BITS_WIDTH(RW),
    .COL_BITS_WIDTH(CW), .BEAT_CNT_WIDTH(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_last(in_last), .in_score(in_score), .in_row(in_row), .in_col(in_col),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_score(res_score), .res_row(res_row), .res_col(res_col),
    .res_beats(res_beats), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int r;
    int c;
  } beat_t;

  beat_t mq[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference: peak of a beat list is the first entry whose score no later
  // entry strictly exceeds.
  function automatic beat_t ref_peak();
    beat_t b;
    b.s = 0; b.r = 0; b.c = 0;
    for (int i = 0; i < mq.size(); i++)
      if (i == 0 || mq[i].s > b.s) b = mq[i];
    return b;
  endfunction

  function automatic int ref_beats();
    return (mq.size() > 1023) ? 1023 : mq.size();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
    mq.delete();
  endtask

  task automatic send_beat(input int s, input int r, input int c, input bit last);
    in_valid = 1'b1; in_last = last;
    in_score = SW'(s); in_row = RW'(r); in_col = CW'(c);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    mq.push_back('{s: s, r: r, c: c});
  endtask

  task automatic do_handshake();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0d exp 0", busy); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0d exp 0", res_valid); end
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err_drop); end
    n_checks++; if ({res_score, res_row, res_col, res_beats} !== '0) begin n_fail++;
      $display("FAIL reset_res got %0d/%0d/%0d/%0d exp 0/0/0/0", res_score, res_row, res_col, res_beats); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_running_max();
    do_start();
    n_checks++; if (busy !== 1'b1 || res_beats !== 0) begin n_fail++;
      $display("FAIL rm_start got busy=%0d beats=%0d exp 1/0", busy, res_beats); end
    send_beat(127, 0, 0, 0);
    n_checks++; if (res_score !== 8'd127) begin n_fail++; $display("FAIL rm_first got %0d exp 127", res_score); end
    send_beat(128, 0, 1, 0);
    send_beat(110, 1, 0, 0);
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL rm_midrun got valid=%0d busy=%0d exp 0/1", res_valid, busy); end
    send_beat(2, 1, 1, 1);
    n_checks++; if (res_valid !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rm_done got valid=%0d busy=%0d exp 1/0", res_valid, busy); end
    n_checks++; if (res_score !== 8'd128 || res_row !== 0 || res_col !== 1 || res_beats !== 4) begin n_fail++;
      $display("FAIL rm_result got %0d/%0d/%0d/%0d exp 128/0/1/4", res_score, res_row, res_col, res_beats); end
    do_handshake();
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rm_idle got valid=%0d busy=%0d exp 0/0", res_valid, busy); end
  endtask

  task automatic test_tie();
    do_start();
    send_beat(9, 0, 2, 0);
    send_beat(18, 0, 3, 0);
    send_beat(18, 1, 2, 1);
    n_checks++; if (res_valid !== 1'b1 || res_score !== 18 || res_row !== 0 || res_col !== 3) begin n_fail++;
      $display("FAIL tie got v=%0d %0d/%0d/%0d exp 1 18/0/3", res_valid, res_score, res_row, res_col); end
    do_handshake();
  endtask

  task automatic test_all_zero();
    do_start();
    send_beat(0, 0, 0, 0);
    send_beat(0, 1, 3, 1);
    n_checks++; if (res_valid !== 1'b1 || res_score !== 0 || res_row !== 0 || res_col !== 0 || res_beats !== 2) begin n_fail++;
      $display("FAIL zero got v=%0d %0d/%0d/%0d/%0d exp 1 0/0/0/2", res_valid, res_score, res_row, res_col, res_beats); end
    do_handshake();
  endtask

  task automatic test_back_to_back();
    do_start();
    send_beat(50, 2, 7, 0);
    send_beat(77, 4, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++; if (res_valid !== 1'b1 || res_score !== 77 || res_row !== 4 || res_col !== 1 || res_beats !== 2) begin n_fail++;
        $display("FAIL bp_hold[%0d] got v=%0d %0d/%0d/%0d/%0d exp 1 77/4/1/2", i, res_valid, res_score, res_row, res_col, res_beats); end
    end
    res_ready = 1'b1; start = 1'b1;
    cyc();
    res_ready = 1'b0; start = 1'b0;
    mq.delete();
    n_checks++; if (busy !== 1'b1 || res_valid !== 1'b0 || res_beats !== 0) begin n_fail++;
      $display("FAIL b2b_start got busy=%0d v=%0d beats=%0d exp 1/0/0", busy, res_valid, res_beats); end
    send_beat(200, 3, 4, 1);
    n_checks++; if (res_valid !== 1'b1 || res_score !== 200 || res_row !== 3 || res_col !== 4 || res_beats !== 1) begin n_fail++;
      $display("FAIL b2b_result got v=%0d %0d/%0d/%0d/%0d exp 1 200/3/4/1", res_valid, res_score, res_row, res_col, res_beats); end
    // A beat offered in DONE is dropped as well.
    send_beat(250, 9, 9, 0);
    n_checks++; if (err_drop !== 1'b1 || res_score !== 200 || res_beats !== 1) begin n_fail++;
      $display("FAIL done_drop got err=%0d score=%0d beats=%0d exp 1/200/1", err_drop, res_score, res_beats); end
    do_handshake();
  endtask

  task automatic test_dropped();
    do_start();
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL drop_clear0 got %0d exp 0", err_drop); end
    send_beat(33, 1, 1, 1);
    do_handshake();
    send_beat(99, 5, 5, 0);
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL drop_set got %0d exp 1", err_drop); end
    n_checks++; if (res_score !== 33 || res_row !== 1 || res_col !== 1 || res_beats !== 1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL drop_unchanged got %0d/%0d/%0d/%0d busy=%0d exp 33/1/1/1 0", res_score, res_row, res_col, res_beats, busy); end
    cyc();
    n_checks++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got %0d exp 1", err_drop); end
    do_start();
    n_checks++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL drop_start_clear got %0d exp 0", err_drop); end
    send_beat(1, 0, 0, 1);
    do_handshake();
    // Beat in the same cycle as start is still dropped and flagged.
    start = 1'b1; in_valid = 1'b1; in_score = 8'd240;
    cyc();
    start = 1'b0; in_valid = 1'b0;
    mq.delete();
    n_checks++; if (err_drop !== 1'b1 || busy !== 1'b1 || res_beats !== 0 || res_score !== 0) begin n_fail++;
      $display("FAIL drop_with_start got err=%0d busy=%0d beats=%0d score=%0d exp 1/1/0/0", err_drop, busy, res_beats, res_score); end
    // start during TRACK is ignored; in_last without in_valid is ignored.
    send_beat(10, 1, 2, 0);
    start = 1'b1; in_last = 1'b1;
    cyc();
    start = 1'b0; in_last = 1'b0;
    n_checks++; if (busy !== 1'b1 || res_valid !== 1'b0 || res_beats !== 1 || res_score !== 10) begin n_fail++;
      $display("FAIL track_ignore got busy=%0d v=%0d beats=%0d score=%0d exp 1/0/1/10", busy, res_valid, res_beats, res_score); end
    send_beat(4, 0, 0, 1);
    do_handshake();
  endtask

  task automatic test_reset_mid_track();
    do_start();
    send_beat(60, 2, 2, 0);
    send_beat(61, 3, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || err_drop !== 1'b0 ||
                    {res_score, res_row, res_col, res_beats} !== '0) begin n_fail++;
      $display("FAIL async_reset got busy=%0d v=%0d err=%0d %0d/%0d/%0d/%0d exp all 0",
               busy, res_valid, err_drop, res_score, res_row, res_col, res_beats); end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle got busy=%0d exp 0", busy); end
    do_start();
    send_beat(5, 2, 2, 1);
    n_checks++; if (res_valid !== 1'b1 || res_score !== 5 || res_row !== 2 || res_col !== 2 || res_beats !== 1) begin n_fail++;
      $display("FAIL post_reset got v=%0d %0d/%0d/%0d/%0d exp 1 5/2/2/1", res_valid, res_score, res_row, res_col, res_beats); end
    do_handshake();
  endtask

  task automatic test_saturation();
    beat_t p;
    do_start();
    for (int i = 0; i < 1030; i++) send_beat(i % 200, i % 32, (i / 32) % 32, 0);
    n_checks++; if (res_beats !== 10'h3ff || busy !== 1'b1) begin n_fail++;
      $display("FAIL sat_count got %0d busy=%0d exp 1023/1", res_beats, busy); end
    send_beat(3, 0, 0, 1);
    p = ref_peak();
    n_checks++; if (res_valid !== 1'b1 || res_beats !== ref_beats() || res_score !== p.s || res_row !== p.r || res_col !== p.c) begin n_fail++;
      $display("FAIL sat_result got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               res_score, res_row, res_col, res_beats, p.s, p.r, p.c, ref_beats()); end
    do_handshake();
  endtask

  task automatic test_random();
    beat_t p;
    for (int m = 0; m < 25; m++) begin
      int n;
      n = $urandom_range(1, 10);
      do_start();
      for (int b = 0; b < n; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_last = $urandom_range(0, 1);
          cyc();
          in_last = 1'b0;
        end
        send_beat((m % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255),
                  $urandom_range(0, 31), $urandom_range(0, 31), b == n - 1);
        p = ref_peak();
        n_checks++; if (res_score !== p.s || res_row !== p.r || res_col !== p.c || res_beats !== ref_beats() ||
                        res_valid !== (b == n - 1) || busy !== (b != n - 1)) begin n_fail++;
          $display("FAIL rand m%0d b%0d got %0d/%0d/%0d/%0d v=%0d busy=%0d exp %0d/%0d/%0d/%0d",
                   m, b, res_score, res_row, res_col, res_beats, res_valid, busy, p.s, p.r, p.c, ref_beats()); end
      end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        cyc();
        n_checks++; if (res_valid !== 1'b1 || res_score !== p.s || res_row !== p.r || res_col !== p.c) begin n_fail++;
          $display("FAIL rand_hold m%0d got v=%0d %0d/%0d/%0d exp 1 %0d/%0d/%0d", m, res_valid, res_score, res_row, res_col, p.s, p.r, p.c); end
      end
      do_handshake();
    end
  endtask

  initial begin
    test_reset();
    test_running_max();
    test_tie();
    test_all_zero();
    test_back_to_back();
    test_dropped();
    test_reset_mid_track();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
